// File: rtl/count_16_bit_if.sv
// Data/valid bundle feeding the population counter and carrying its result back.
// The producer side uses the master modport and the counter uses the slave modport.
interface count_16_bit_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
);

  logic [DATA_W-1:0] input_data;
  logic              in_valid;
  logic [CNT_W-1:0]  count;
  logic              out_valid;

  modport master (
    output input_data,
    output in_valid,
    input  count,
    input  out_valid
  );

  modport slave (
    input  input_data,
    input  in_valid,
    output count,
    output out_valid
  );

endinterface

// File: rtl/count_16_bit.sv
// Registered population counter for a 16-bit word.
// The ones-count is formed by a four-level adder tree within one cycle.
// It is captured on the next rising edge whenever in_valid is high.
// If in_valid is low, the count register holds, so the data lines are don't-care.
module count_16_bit (
  input  logic            clk,
  input  logic            rst,
  count_16_bit_if.slave   bus
);

  localparam int DATA_W = 16;
  localparam int CNT_W  = 5;

  // Each tree level widens the partial sums by one bit.
  // The top level's 5 bits hold the maximum of 16 exactly.
  logic [1:0]       level1Sum [8];
  logic [2:0]       level2Sum [4];
  logic [3:0]       level3Sum [2];
  logic [CNT_W-1:0] popCount;

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;
  logic             outValid_d;
  logic             outValid_q;

  // Sum adjacent bit pairs, then adjacent partial sums, until one total remains.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      level1Sum[i] = {1'b0, bus.input_data[2*i]} + {1'b0, bus.input_data[2*i+1]};
    end
    for (int i = 0; i < 4; i++) begin
      level2Sum[i] = {1'b0, level1Sum[2*i]} + {1'b0, level1Sum[2*i+1]};
    end
    for (int i = 0; i < 2; i++) begin
      level3Sum[i] = {1'b0, level2Sum[2*i]} + {1'b0, level2Sum[2*i+1]};
    end
    popCount = {1'b0, level3Sum[0]} + {1'b0, level3Sum[1]};
  end

  // Load a new count only for a valid word; otherwise keep the last result and drop valid.
  always_comb begin
    count_d    = count_q;
    outValid_d = 1'b0;
    if (bus.in_valid) begin
      count_d    = popCount;
      outValid_d = 1'b1;
    end
  end

  // Output registers; reset wins over any word presented on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      outValid_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      outValid_q <= outValid_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.out_valid = outValid_q;

endmodule

// File: tb/tb_count_16_bit.sv
// Directed and random self-checking bench for the 16-bit population counter.
module tb_count_16_bit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  count_16_bit_if #(.DATA_W(16), .CNT_W(5)) bus ();

  count_16_bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: counts the set bits one at a time.
  function automatic logic [4:0] onesRef(input logic [15:0] d);
    logic [4:0] n;
    n = '0;
    for (int k = 0; k < 16; k++) begin
      if (d[k]) n = n + 5'd1;
    end
    return n;
  endfunction

  // Drive the inputs, then advance past one rising edge.
  task automatic applyStimulus(input logic r, input logic [15:0] d, input logic v);
    rst            = r;
    bus.input_data = d;
    bus.in_valid   = v;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [4:0] expCount, input logic expValid);
    checks++;
    assert (bus.count === expCount) else begin
      errors++;
      $error("[TB] FAIL %s count: got %0d, expected %0d", tag, bus.count, expCount);
    end
    checks++;
    assert (bus.out_valid === expValid) else begin
      errors++;
      $error("[TB] FAIL %s out_valid: got %0b, expected %0b", tag, bus.out_valid, expValid);
    end
  endtask

  initial begin
    logic [15:0] d;
    logic        v;
    logic        r;
    logic [4:0]  modelCount;

    checks = 0;
    errors = 0;
    rst            = 1'b1;
    bus.input_data = 16'hFFFF;
    bus.in_valid   = 1'b1;

    $display("[TB] reset held with a valid all-ones word");
    applyStimulus(1'b1, 16'hFFFF, 1'b1);
    checkOutput("reset0", 5'd0, 1'b0);
    applyStimulus(1'b1, 16'hFFFF, 1'b1);
    checkOutput("reset1", 5'd0, 1'b0);

    $display("[TB] back-to-back words after reset release");
    applyStimulus(1'b0, 16'b1111111111111111, 1'b1);
    checkOutput("allOnes", 5'b10000, 1'b1);
    applyStimulus(1'b0, 16'b1111111111110000, 1'b1);
    checkOutput("b2b12", 5'b01100, 1'b1);
    applyStimulus(1'b0, 16'b0111111111111111, 1'b1);
    checkOutput("b2b15", 5'b01111, 1'b1);

    $display("[TB] hold with in_valid low");
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("hold0", 5'd15, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("hold1", 5'd15, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("hold2", 5'd15, 1'b0);
    applyStimulus(1'b0, 16'hxxxx, 1'b0);
    checkOutput("holdX", 5'd15, 1'b0);

    $display("[TB] boundary patterns");
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("zero", 5'd0, 1'b1);
    applyStimulus(1'b0, 16'h0001, 1'b1);
    checkOutput("lsb", 5'd1, 1'b1);
    applyStimulus(1'b0, 16'h8000, 1'b1);
    checkOutput("msb", 5'd1, 1'b1);
    applyStimulus(1'b0, 16'hAAAA, 1'b1);
    checkOutput("aaaa", 5'd8, 1'b1);
    applyStimulus(1'b0, 16'h5555, 1'b1);
    checkOutput("5555", 5'd8, 1'b1);

    $display("[TB] reset mid-stream discards the word on that edge");
    applyStimulus(1'b1, 16'hFFFF, 1'b1);
    checkOutput("midReset", 5'd0, 1'b0);
    applyStimulus(1'b0, 16'h00FF, 1'b1);
    checkOutput("afterReset", 5'd8, 1'b1);

    $display("[TB] random words with random valid");
    modelCount = 5'd8;
    for (int i = 0; i < 1000; i++) begin
      d = 16'($urandom);
      v = 1'($urandom_range(0, 1));
      r = (i == 500);
      applyStimulus(r, d, v);
      if (r) begin
        modelCount = 5'd0;
        checkOutput("randReset", 5'd0, 1'b0);
      end else if (v) begin
        modelCount = onesRef(d);
        checkOutput("randValid", modelCount, 1'b1);
      end else begin
        checkOutput("randHold", modelCount, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_16_bit.md
Name: count_16_bit

Overview:
- Registered population counter: counts the '1' bits in a 16-bit input word and presents the total on a 5-bit output.
- Single clock domain, one-cycle latency, valid-qualified.
- Used as a utility block wherever a ones-count of a data word is needed, e.g. for weight checks or density statistics.

Parameters:
- DATA_W, 16, width of the input word; the behaviour and test values below are fixed for 16.
- CNT_W, 5, width of the count output; must equal ceil(log2(DATA_W+1)), which is 5 for 16.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- input_data  input  16  word whose set bits are counted.
- in_valid  input  1  input_data is sampled on a rising clk edge only when this is high.
- count  output  5  number of '1' bits in the last sampled word, range 0..16.
- out_valid  output  1  high for exactly the cycle(s) in which count reflects a word sampled on the previous edge.

Behaviour:
- All state updates on the rising edge of clk. Synchronous reset is active-high, and rst has priority over every other input.
- Reset values:
  - count = 0
  - out_valid = 0
- Normal operation, at each rising edge with rst=0:
  - If in_valid=1: count <= number of '1' bits in input_data, and out_valid <= 1.
  - If in_valid=0: count holds its previous value, and out_valid <= 0.
- Latency: exactly 1 clock from the edge sampling input_data to the updated count. No input stall; a new word is accepted every cycle, so throughput is 1 word/clock.
- Arithmetic:
  - Unsigned sum of the 16 input bits.
  - Result zero-extended into 5 bits.
  - Maximum 16 = 5'b10000. No overflow is possible, and no saturation or wrap logic is needed.
- Combinational count path: adder tree or bit-serial sum, designer's choice. It must close timing within one clock and introduce no extra pipeline stage.
- X/Z on input_data while in_valid=0 must not affect count.
- Reset mid-stream: rst asserted on an edge where in_valid=1 discards that word (count=0, out_valid=0). The first word accepted after rst deasserts appears on the following edge.
- Back-to-back valid words: count updates on every edge, with no bubbles. out_valid stays high continuously while in_valid stays high.
- No latches, no asynchronous logic, no internal state beyond the count and out_valid registers.

Test Plan:
- Reset: hold rst=1 for 2 clocks with in_valid=1 and input_data=16'hFFFF -> count=0 and out_valid=0 throughout. Release rst -> first valid result appears one edge later.
- All ones: input_data=16'b1111111111111111 with in_valid=1 -> next edge count=5'b10000 (16), out_valid=1.
- Back-to-back sequence, one word per clock:
  - 16'b1111111111110000 -> count=5'b01100 (12)
  - 16'b0111111111111111 -> count=5'b01111 (15)
  - each result lands exactly one clock after its input, and out_valid stays 1 across all three words.
- Boundaries and patterns, each checked one edge later:
  - 16'h0000 -> count 0
  - 16'h0001 -> count 1
  - 16'h8000 -> count 1
  - 16'hAAAA -> count 8
  - 16'h5555 -> count 8
- Hold behaviour: after count=15, drive in_valid=0 with input_data=16'h0000 for 3 clocks -> count stays 15 and out_valid=0.
- Random: 1000 random words with random in_valid. A reference model (bitwise sum) is compared against count on every cycle in which out_valid=1, plus a check that reset asserted mid-stream clears both outputs on the next edge.
